// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width default, op codes and op classification.
// Imported by the issue stage and by the ALU itself.
package alu_pkg;

    localparam int N_DEFAULT = 32;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_XOR = 3'b100;
    localparam alu_op_t ALU_NOR = 3'b101;
    localparam alu_op_t ALU_SLL = 3'b110;
    localparam alu_op_t ALU_SRA = 3'b111;

    // Shifts take the amount on a and the shifted value on b.
    function automatic logic is_shift(alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_stage_operand_fwd_slot.sv
// One held source operand: address/data register with writeback bypass at
// capture time and writeback snooping while the entry is held.
module operand_fwd_slot #(
    parameter int N       = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               snoop,
    input  logic [REGBITS-1:0] in_addr,
    input  logic [N-1:0]       in_data,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_addr,
    input  logic [N-1:0]       wb_data,
    output logic [N-1:0]       data
);

    logic [REGBITS-1:0] addr_reg, addr_next;
    logic [N-1:0]       data_reg, data_next;
    logic               wb_live;

    // Register 0 is hard-wired zero, so writes to it never forward.
    assign wb_live = wb_en && (wb_addr != '0);

    always_comb begin
        addr_next = addr_reg;
        data_next = data_reg;
        if (capture) begin
            addr_next = in_addr;
            data_next = (wb_live && (wb_addr == in_addr)) ? wb_data : in_data;
        end else if (snoop && wb_live && (wb_addr == addr_reg)) begin
            data_next = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            addr_reg <= addr_next;
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: single-entry valid/ready register that presents a, b and
// alucontrol to the ALU and keeps held register operands fresh from writeback.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_alucontrol,
    input  logic [REGBITS-1:0] in_rs1_addr,
    input  logic [REGBITS-1:0] in_rs2_addr,
    input  logic [N-1:0]       in_rs1_data,
    input  logic [N-1:0]       in_rs2_data,
    input  logic [N-1:0]       in_imm,
    input  logic               in_use_imm,
    input  logic [REGBITS-1:0] in_rd_addr,
    input  logic               in_reg_write,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_addr,
    input  logic [N-1:0]       wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       a,
    output logic [N-1:0]       b,
    output logic [2:0]         alucontrol,
    output logic [REGBITS-1:0] out_rd_addr,
    output logic               out_reg_write
);

    logic               valid_reg, valid_next;
    alu_op_t            op_reg, op_next;
    logic [N-1:0]       imm_reg, imm_next;
    logic               use_imm_reg, use_imm_next;
    logic [REGBITS-1:0] rd_reg, rd_next;
    logic               reg_write_reg, reg_write_next;

    logic capture;
    logic snoop;

    logic [1:0][REGBITS-1:0] src_addr;
    logic [1:0][N-1:0]       src_data_in;
    logic [1:0][N-1:0]       src_data;

    assign in_ready = flush | ~valid_reg | out_ready;
    assign capture  = in_valid & in_ready & ~flush;
    // Snooping only matters for an entry that survives this cycle.
    assign snoop    = valid_reg & ~out_ready & ~flush;

    assign src_addr    = {in_rs2_addr, in_rs1_addr};
    assign src_data_in = {in_rs2_data, in_rs1_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            operand_fwd_slot #(
                .N       (N),
                .REGBITS (REGBITS)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .capture (capture),
                .snoop   (snoop),
                .in_addr (src_addr[gi]),
                .in_data (src_data_in[gi]),
                .wb_en   (wb_en),
                .wb_addr (wb_addr),
                .wb_data (wb_data),
                .data    (src_data[gi])
            );
        end
    endgenerate

    always_comb begin
        valid_next     = valid_reg;
        op_next        = op_reg;
        imm_next       = imm_reg;
        use_imm_next   = use_imm_reg;
        rd_next        = rd_reg;
        reg_write_next = reg_write_reg;
        if (flush) begin
            valid_next = 1'b0;
        end else if (capture) begin
            valid_next     = 1'b1;
            op_next        = alu_op_t'(in_alucontrol);
            imm_next       = in_imm;
            use_imm_next   = in_use_imm;
            rd_next        = in_rd_addr;
            reg_write_next = in_reg_write;
        end else if (out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            op_reg        <= ALU_ADD;
            imm_reg       <= '0;
            use_imm_reg   <= 1'b0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
        end else begin
            valid_reg     <= valid_next;
            op_reg        <= op_next;
            imm_reg       <= imm_next;
            use_imm_reg   <= use_imm_next;
            rd_reg        <= rd_next;
            reg_write_reg <= reg_write_next;
        end
    end

    logic [N-1:0] second;
    assign second = use_imm_reg ? imm_reg : src_data[1];

    always_comb begin
        a = src_data[0];
        b = second;
        if (is_shift(op_reg)) begin
            a = second;
            b = src_data[0];
        end
    end

    assign out_valid     = valid_reg;
    assign alucontrol    = op_reg;
    assign out_rd_addr   = rd_reg;
    assign out_reg_write = reg_write_reg & valid_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed steps then random traffic,
// checked against a register-file view of what each held operand must equal.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [2:0]  in_alucontrol;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm, in_reg_write;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] a, b;
    logic [2:0]  alucontrol;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int compared   = 0;
    int mismatched = 0;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_alucontrol(in_alucontrol), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .a(a), .b(b), .alucontrol(alucontrol),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    // Reference: architectural register file plus the op the stage should hold.
    logic [31:0] regs [32];
    logic        ev;
    logic [2:0]  e_op;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_imm;
    logic        e_ui, e_rw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_alucontrol = 3'b000;
        in_rs1_addr = '0; in_rs2_addr = '0; in_imm = '0; in_use_imm = 1'b0;
        in_rd_addr = '0; in_reg_write = 1'b0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; out_ready = 1'b1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] imm, input logic ui, input logic [4:0] rd);
        in_valid = 1'b1; in_alucontrol = op; in_rs1_addr = r1; in_rs2_addr = r2;
        in_imm = imm; in_use_imm = ui; in_rd_addr = rd; in_reg_write = (rd != 0);
    endtask

    // One clock: drive regfile read data, check in_ready, clock, update model, check outputs.
    task automatic cycle();
        logic        exp_ready;
        logic [31:0] d1, d2, sec, ea, eb;
        in_rs1_data = regs[in_rs1_addr];
        in_rs2_data = regs[in_rs2_addr];
        #1;
        exp_ready = flush | ~ev | out_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        @(posedge clk);
        if (rst) begin
            ev = 1'b0;
        end else if (flush) begin
            ev = 1'b0;
        end else if (in_valid && exp_ready) begin
            ev = 1'b1; e_op = in_alucontrol; e_rs1 = in_rs1_addr; e_rs2 = in_rs2_addr;
            e_imm = in_imm; e_ui = in_use_imm; e_rd = in_rd_addr; e_rw = in_reg_write;
        end else if (out_ready) begin
            ev = 1'b0;
        end
        if (!rst && wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        if (ev) begin
            d1  = regs[e_rs1];
            d2  = regs[e_rs2];
            sec = e_ui ? e_imm : d2;
            ea  = (e_op == 3'b110 || e_op == 3'b111) ? sec : d1;
            eb  = (e_op == 3'b110 || e_op == 3'b111) ? d1 : sec;
            chk("a", a, ea);
            chk("b", b, eb);
            chk("alucontrol", {29'b0, alucontrol}, {29'b0, e_op});
            chk("out_rd_addr", {27'b0, out_rd_addr}, {27'b0, e_rd});
            chk("out_reg_write", {31'b0, out_reg_write}, {31'b0, e_rw});
            $display("t=%0t valid op=%0d a=%h b=%h rd=%0d rw=%0b", $time, alucontrol, a, b,
                     out_rd_addr, out_reg_write);
        end else begin
            chk("out_reg_write_idle", {31'b0, out_reg_write}, 32'd0);
            $display("t=%0t idle", $time);
        end
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        idle_inputs();
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        ev = 1'b0; e_op = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_ui = 1'b0; e_rd = '0; e_rw = 1'b0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset then idle
        cycle();
        idle_inputs();
        cycle();
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_alucontrol", {29'b0, alucontrol}, 32'd0);
        chk("rst_rd", {27'b0, out_rd_addr}, 32'd0);

        // ADD x3 + x4
        wb_write(5'd3, 32'h0001_0001);
        wb_write(5'd4, 32'h0001_0002);
        idle_inputs(); set_op(3'b000, 5'd3, 5'd4, 32'd0, 1'b0, 5'd10);
        cycle();
        chk("add_a", a, 32'h0001_0001);
        chk("add_b", b, 32'h0001_0002);
        chk("add_sum", a + b, 32'h0002_0003);

        // SRA with immediate shift amount
        wb_write(5'd1, 32'h8000_0000);
        idle_inputs(); set_op(3'b111, 5'd1, 5'd2, 32'd5, 1'b1, 5'd11);
        cycle();
        chk("sra_a", a, 32'd5);
        chk("sra_b", b, 32'h8000_0000);

        // Hold a SUB and snoop x7; then a write to x0 must not disturb it
        wb_write(5'd7, 32'h1111_1111);
        idle_inputs(); set_op(3'b001, 5'd7, 5'd4, 32'd0, 1'b0, 5'd12); out_ready = 1'b0;
        cycle();
        set_op(3'b010, 5'd5, 5'd6, 32'd0, 1'b0, 5'd13); out_ready = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0002_0003;
        cycle();
        chk("snoop_a", a, 32'h0002_0003);
        chk("snoop_rd", {27'b0, out_rd_addr}, 32'd12);
        wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        cycle();
        chk("x0_a", a, 32'h0002_0003);
        idle_inputs();
        cycle();
        chk("drained", {31'b0, out_valid}, 32'd0);

        // Capture-time bypass on rs2 = x9
        idle_inputs(); set_op(3'b011, 5'd3, 5'd9, 32'd0, 1'b0, 5'd14);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hFF00_FF00;
        cycle();
        chk("bypass_b", b, 32'hFF00_FF00);

        // Flush a held entry while new input is offered
        idle_inputs(); set_op(3'b100, 5'd3, 5'd4, 32'd0, 1'b0, 5'd15); out_ready = 1'b0;
        cycle();
        set_op(3'b101, 5'd4, 5'd3, 32'd0, 1'b0, 5'd16); out_ready = 1'b0; flush = 1'b1;
        cycle();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);

        // Back-to-back stream of four ops
        for (int i = 1; i <= 4; i++) begin
            idle_inputs(); set_op(3'(i), 5'd3, 5'd4, 32'(i), 1'b0, 5'(i));
            cycle();
            chk("stream_rd", {27'b0, out_rd_addr}, 32'(i));
        end
        idle_inputs();
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            in_valid      = $urandom_range(0, 1);
            in_alucontrol = 3'($urandom);
            in_rs1_addr   = 5'($urandom_range(0, 7));
            in_rs2_addr   = 5'($urandom_range(0, 7));
            in_imm        = $urandom;
            in_use_imm    = $urandom_range(0, 1);
            in_rd_addr    = 5'($urandom);
            in_reg_write  = $urandom_range(0, 1);
            wb_en         = rst ? 1'b0 : 1'($urandom_range(0, 1));
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            out_ready     = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Registered ID/EX issue stage directly upstream of the 32-bit behavioural ALU. It accepts a decoded ALU operation, captures it with a valid/ready handshake and holds it across stalls. It selects and presents the ALU inputs a, b and alucontrol. While it holds an entry, it snoops the writeback bus so that held register operands never go stale.

Parameters:
N, 32, data width of operands, immediate and writeback data
REGBITS, 5, register address width; address 0 is hard-wired zero and is never forwarded

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  kill held entry and any same-cycle input
in_valid  input  1  upstream has a decoded op
in_ready  output  1  stage can accept this cycle
in_alucontrol  input  3  ALU op code
in_rs1_addr  input  REGBITS  source register 1 address
in_rs2_addr  input  REGBITS  source register 2 address
in_rs1_data  input  N  register file read data for rs1
in_rs2_data  input  N  register file read data for rs2
in_imm  input  N  immediate, already sign/zero extended
in_use_imm  input  1  immediate replaces second operand
in_rd_addr  input  REGBITS  destination register
in_reg_write  input  1  op writes rd
wb_en  input  1  writeback bus write enable
wb_addr  input  REGBITS  writeback destination
wb_data  input  N  writeback value
out_valid  output  1  a/b/alucontrol are valid for ALU
out_ready  input  1  downstream EX consumes entry
a  output  N  ALU operand a
b  output  N  ALU operand b
alucontrol  output  3  ALU op code to ALU
out_rd_addr  output  REGBITS  held rd
out_reg_write  output  1  held reg_write AND out_valid

Behaviour:
- Single-entry pipeline register. in_ready = flush | ~out_valid | out_ready, combinational; no bubble on back-to-back streaming.
- Capture: when in_valid & in_ready & ~flush, all in_* fields are registered and out_valid=1 next cycle.
- Hold: when out_valid & ~out_ready, all held fields are stable except the operand-snoop updates below.
- Drain: when out_valid & out_ready & no capture, out_valid=0 next cycle.
- Flush has priority over capture. On flush, out_valid=0 next cycle and the same-cycle input is discarded (in_ready=1).
- Capture-time bypass: if wb_en & wb_addr!=0 & wb_addr==in_rsX_addr, store wb_data instead of in_rsX_data. This covers the register-file write/read same-cycle case.
- Hold-time snoop: while out_valid, if wb_en & wb_addr!=0 & wb_addr==held rsX_addr, overwrite held rsX_data next cycle.
  - Applies to rs1 and rs2 independently; both update if the addresses are equal.
  - A snoop on the cycle the entry drains has no effect.
- Operand selection (combinational from held fields):
  - Shifts (SLL 3'b110, SRA 3'b111): the shift amount is on a and the value is on b. a = use_imm ? imm : rs2_data; b = rs1_data.
  - All other ops: a = rs1_data; b = use_imm ? imm : rs2_data.
- Latency: exactly 1 cycle from accepted input to out_valid.
- Reset (synchronous, dominates flush and capture): out_valid=0 and all held fields 0. Hence a=0, b=0, alucontrol=3'b000 (ADD), out_rd_addr=0, out_reg_write=0, in_ready=1 after reset.
- Reset mid-hold discards the entry with no snoop applied.

Decomposition:
- Shared package alu_pkg holds:
  - N_DEFAULT=32.
  - The 3-bit op code localparams ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_NOR=101, ALU_SLL=110, ALU_SRA=111.
  - typedef alu_op_t (logic [2:0]).
  - The ALU also imports this package.
- One sub-module, operand_fwd_slot, instantiated twice (rs1, rs2). It holds the address and data register and implements capture-time bypass plus hold-time snoop.

Test Plan:
- Reset then idle -> out_valid=0, a=0, b=0, alucontrol=000, in_ready=1.
- ADD rs1=x3(0x0001_0001), rs2=x4(0x0001_0002), out_ready=1 -> next cycle out_valid=1, a=0x0001_0001, b=0x0001_0002, alucontrol=000; the ALU result is 0x0002_0003.
- SRA with use_imm, imm=5, rs1 data 0x8000_0000 -> a=5, b=0x8000_0000, alucontrol=111.
- Hold with out_ready=0 and SUB rs1=x7; pulse wb_en, wb_addr=7, wb_data=0x0002_0003 -> a becomes 0x0002_0003 next cycle, in_ready=0, and on release the entry drains once. Repeat with wb_addr=0 -> no change.
- Capture with wb_en, wb_addr=in_rs2_addr=9, wb_data=0xFF00_FF00, regfile data 0x0 -> b=0xFF00_FF00.
- Held entry plus flush with in_valid=1 in the same cycle -> out_valid=0 next cycle, input discarded. Back-to-back stream of 4 ops with out_ready=1 -> 4 consecutive out_valid cycles in order.
